// File: rtl/adder_operand_loader.sv
// Byte-serial loader for a combinational 64-bit adder.
//
// Sixteen bytes arrive little-endian over a valid/ready stream: eight for
// operand A, then eight for operand B. Carry-in comes with the last byte.
// The operands are held on the adder inputs for EXEC_CYCLES cycles. The
// sum and carry are then captured and offered on a valid/ready result port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD_A | shifting operand A bytes into add_a
// LOAD_B | shifting operand B bytes into add_b; cin taken on last byte
// EXEC   | adder inputs held stable while the adder settles
// DONE   | result held on res_sum/res_cout until res_ready
module adder_operand_loader #(
  // Settle window in cycles; legal range 1..15 (fits the 4-bit exec counter).
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_cin,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  input  logic [63:0] add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_sum,
  output logic        res_cout
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, EXEC, DONE} state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] byte_cnt;
  logic [3:0] exec_cnt;
  logic       accept;
  logic       last_byte;
  logic       exec_last;

  assign last_byte = (byte_cnt == 3'd7);
  assign exec_last = (exec_cnt == EXEC_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  // Next-state and stream handshake; in_ready is masked by reset so no
  // byte can be taken on the edge that reset is being applied.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept && last_byte) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept && last_byte) state_nxt = EXEC;
      end
      EXEC: begin
        if (exec_last) state_nxt = DONE;
      end
      DONE: begin
        if (res_ready) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  // Operand shifting, counters and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 3'd0;
      exec_cnt  <= 4'd0;
      add_a     <= 64'd0;
      add_b     <= 64'd0;
      add_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= 64'd0;
      res_cout  <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (accept) begin
            add_a    <= {in_data, add_a[63:8]};
            byte_cnt <= byte_cnt + 3'd1;
          end
        end
        LOAD_B: begin
          if (accept) begin
            add_b    <= {in_data, add_b[63:8]};
            byte_cnt <= byte_cnt + 3'd1;
            if (last_byte) begin
              add_cin  <= in_cin;
              exec_cnt <= 4'd0;
            end
          end
        end
        EXEC: begin
          exec_cnt <= exec_cnt + 4'd1;
          if (exec_last) begin
            res_sum   <= add_sum;
            res_cout  <= add_cout;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            byte_cnt  <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_operand_loader.md
# adder_operand_loader

Byte-serial front end for `serial_adder_64bit`. It accepts two 64-bit operands one byte at a time over a valid/ready stream and drives them, with carry-in, onto the adder's `a`/`b`/`cin` ports. After a programmable settle window it captures `sum`/`cout` and presents the result on a valid/ready output. It sits directly upstream of the adder and also consumes its outputs, so the combinational adder can be reached from narrow byte-wide interfaces.

## Interface
- `EXEC_CYCLES`, default 1: cycles the adder inputs are held stable before `sum`/`cout` are captured; legal range 1..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a byte is offered on `in_data`.
- `in_ready` output 1: the block accepts a byte this cycle.
- `in_data` input 8: operand byte.
- `in_cin` input 1: carry-in; sampled only with the 16th (final) byte.
- `add_a` output 64: operand A to the adder's `a`.
- `add_b` output 64: operand B to the adder's `b`.
- `add_cin` output 1: to the adder's `cin`.
- `add_sum` input 64: from the adder's `sum`.
- `add_cout` input 1: from the adder's `cout`.
- `res_valid` output 1: a result is held on `res_sum`/`res_cout`.
- `res_ready` input 1: the consumer accepts the result.
- `res_sum` output 64: captured sum.
- `res_cout` output 1: captured carry-out.

## Operation
- The FSM has four states: LOAD_A, LOAD_B, EXEC and DONE. The reset state is LOAD_A, with the byte counter and exec counter at 0.
- A byte is accepted on any rising edge where `in_valid && in_ready`. `in_ready` is 1 in LOAD_A and LOAD_B and 0 in EXEC and DONE. While `rst` is high, `in_ready` is 0.
- Byte order is little-endian: the first byte accepted lands in bits [7:0]. Implement this by shifting right, `reg <= {in_data, reg[63:8]}`.
- LOAD_A:
  - Each accept shifts into `add_a` and increments the 3-bit byte counter.
  - On the 8th accept (counter 7), the counter wraps to 0 and the FSM moves to LOAD_B.
- LOAD_B:
  - Each accept shifts into `add_b` in the same way.
  - On the 8th accept, `add_cin <= in_cin`, the exec counter is cleared, and the FSM moves to EXEC.
- EXEC:
  - `add_a`, `add_b` and `add_cin` are held constant.
  - The exec counter increments each cycle.
  - On the edge where the counter equals `EXEC_CYCLES-1`, the block captures `res_sum <= add_sum` and `res_cout <= add_cout`, sets `res_valid <= 1`, and moves to DONE.
- DONE:
  - The result is held stable while `res_valid && !res_ready`.
  - On an edge with `res_ready`, the block clears `res_valid`, returns to LOAD_A and clears the byte counter.
  - `add_a`, `add_b`, `res_sum` and `res_cout` keep their values until overwritten.
- Gaps in `in_valid` stall loading with no loss of state; any number of idle cycles between bytes is legal.
- The adder outputs are ignored outside EXEC. Partially shifted operands are visible on `add_a`/`add_b` during loading, and this is allowed.
- Arithmetic is entirely inside the adder. The block does no width extension or truncation: the 64-bit sum plus a separate carry give 65 bits of result.

## Timing
- Reset values: `in_ready` 0 while `rst`=1 and 1 from the first cycle after release; `add_a` 0, `add_b` 0, `add_cin` 0, `res_valid` 0, `res_sum` 0, `res_cout` 0.
- Latency:
  - The last B byte is accepted at edge k.
  - `res_valid` rises at edge k+`EXEC_CYCLES`.
  - With the default, the result is valid 1 cycle after the final byte.
- Minimum transaction length is 16 + `EXEC_CYCLES` + 1 cycles: 16 bytes, the settle window, and a 1-cycle handshake when `res_ready` is tied high.
- There is no overlap between transactions: a new A byte can be accepted, at the earliest, in the cycle after the result handshake.
- Reset asserted mid-operation, in any state, takes effect on the next edge:
  - partial operands are discarded;
  - all outputs return to their reset values;
  - an undelivered result is dropped.
- `in_valid` offered during EXEC or DONE is not accepted. The byte is not consumed.

## Test plan
- Operands A=2, B=5, `in_cin`=0, streamed back-to-back -> `res_sum`=7, `res_cout`=0, with `res_valid` rising exactly 1 edge after byte 16.
- A=20, B=2012, `in_cin`=1; then A=75, B=75123, `in_cin`=1 -> 2033 then 75199, both with `res_cout`=0. The two transactions are sequential with no bleed-over.
- A=64'hFFFF_FFFF_FFFF_FFFF, B=1, `in_cin`=0 -> `res_sum`=0 and `res_cout`=1. Also A=B=all-ones with `in_cin`=1 -> `res_sum`=all-ones and `res_cout`=1.
- Random `in_valid` gaps, plus `res_ready` held low for 5 cycles in DONE with A=1234, B=1123 -> `res_sum`=2357 held stable, `in_ready`=0 throughout, and the handshake completing on the first `res_ready` edge.
- Reset asserted after 5 A bytes; then A=128, B=12890, `in_cin`=0 -> `res_sum`=13018 and all outputs at their reset values the cycle after reset.
- `EXEC_CYCLES`=3 with A=200, B=20123 -> `res_sum`=20323, with `res_valid` rising exactly 3 edges after the final byte.
